// File: rtl/layer_output_collector_if.sv
// Bus bundle for layer_output_collector: per-node result inputs and the
// single-word output stream with its status flags.
interface layer_output_collector_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUMBER_OF_NODE = 32,
    parameter int ADDRESS_WIDTH  = 10
);
    logic [NUMBER_OF_NODE-1:0]            i_valid;
    logic [NUMBER_OF_NODE*DATA_WIDTH-1:0] i_data;
    logic                                 i_ready;
    logic [DATA_WIDTH-1:0]                o_data;
    logic [ADDRESS_WIDTH-1:0]             o_addr;
    logic                                 o_valid;
    logic                                 o_last;
    logic                                 o_done;
    logic                                 o_overrun;

    modport master (
        output i_valid, i_data, i_ready,
        input  o_data, o_addr, o_valid, o_last, o_done, o_overrun
    );

    modport slave (
        input  i_valid, i_data, i_ready,
        output o_data, o_addr, o_valid, o_last, o_done, o_overrun
    );
endinterface

// File: rtl/layer_output_collector.sv
// Gathers one result per node as they arrive in any order, then streams them
// out in node-index order with a valid/ready handshake and a done pulse.
module layer_output_collector #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUMBER_OF_NODE = 32,
    parameter int ADDRESS_WIDTH  = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clear,
    layer_output_collector_if.slave  bus
);

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_STREAM  = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    localparam int IDX_W = (NUMBER_OF_NODE > 1) ? $clog2(NUMBER_OF_NODE) : 1;
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(NUMBER_OF_NODE - 1);

    logic [1:0]                state;
    logic [NUMBER_OF_NODE-1:0] captured;
    logic [NUMBER_OF_NODE-1:0] new_cap;
    logic [NUMBER_OF_NODE-1:0] dup_valid;
    logic                      all_captured;
    logic [ADDRESS_WIDTH-1:0]  addr;
    logic                      overrun;
    logic [IDX_W-1:0]          rd_idx;
    logic [DATA_WIDTH-1:0]     stored [NUMBER_OF_NODE];

    // Only uncaptured nodes are accepted while collecting; anything else is an overrun.
    always_comb begin
        new_cap   = '0;
        dup_valid = bus.i_valid;
        if (state == ST_COLLECT) begin
            new_cap   = bus.i_valid & ~captured;
            dup_valid = bus.i_valid & captured;
        end
        all_captured = &(captured | new_cap);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_COLLECT;
            captured <= '0;
            addr     <= '0;
            overrun  <= 1'b0;
        end else if (i_clear) begin
            state    <= ST_COLLECT;
            captured <= '0;
            addr     <= '0;
            overrun  <= 1'b0;
        end else begin
            if (|dup_valid) begin
                overrun <= 1'b1;
            end
            case (state)
                ST_COLLECT: begin
                    captured <= captured | new_cap;
                    if (all_captured) begin
                        state <= ST_STREAM;
                        addr  <= '0;
                    end
                end
                ST_STREAM: begin
                    if (bus.i_ready) begin
                        if (addr == LAST_ADDR) begin
                            state <= ST_DONE;
                            addr  <= '0;
                        end else begin
                            addr <= addr + ADDRESS_WIDTH'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state    <= ST_COLLECT;
                    captured <= '0;
                end
                default: begin
                    state    <= ST_COLLECT;
                    captured <= '0;
                    addr     <= '0;
                end
            endcase
        end
    end

    // Result storage: written only on a first capture, never while clearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUMBER_OF_NODE; k++) begin
                stored[k] <= '0;
            end
        end else if (!i_clear) begin
            for (int k = 0; k < NUMBER_OF_NODE; k++) begin
                if (new_cap[k]) begin
                    stored[k] <= bus.i_data[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign rd_idx        = addr[IDX_W-1:0];
    assign bus.o_valid   = (state == ST_STREAM);
    assign bus.o_data    = bus.o_valid ? stored[rd_idx] : '0;
    assign bus.o_addr    = addr;
    assign bus.o_last    = bus.o_valid && (addr == LAST_ADDR);
    assign bus.o_done    = (state == ST_DONE);
    assign bus.o_overrun = overrun;

endmodule

// File: doc/layer_output_collector.md
LAYER_OUTPUT_COLLECTOR -- requirements
Module: layer_output_collector

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the width of one node result (IEEE-754 single precision).
REQ-002 SHALL have parameter NUMBER_OF_NODE, default 32, meaning the number of parallel node results collected per layer.
REQ-003 SHALL have parameter ADDRESS_WIDTH, default 10, meaning the width of the node index output; must satisfy 2^ADDRESS_WIDTH >= NUMBER_OF_NODE.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port i_clear, input, 1 bit: synchronous abort/restart of collection.
REQ-007 SHALL have port i_valid, input, NUMBER_OF_NODE bits: per-node result-valid pulses from the upstream layer's nodes.
REQ-008 SHALL have port i_data, input, NUMBER_OF_NODE*DATA_WIDTH bits: node k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port i_ready, input, 1 bit: the downstream stage accepts the current word.
REQ-010 SHALL have port o_data, output, DATA_WIDTH bits: the streamed node result.
REQ-011 SHALL have port o_addr, output, ADDRESS_WIDTH bits: the node index of o_data.
REQ-012 SHALL have port o_valid, output, 1 bit: o_data and o_addr are valid.
REQ-013 SHALL have port o_last, output, 1 bit: the current word is node NUMBER_OF_NODE-1.
REQ-014 SHALL have port o_done, output, 1 bit: a one-cycle pulse after the final transfer.
REQ-015 SHALL have port o_overrun, output, 1 bit: a sticky flag for a node valid that arrives while it cannot be accepted.

Function
REQ-016 SHALL implement three states: COLLECT, STREAM and DONE.
REQ-017 In COLLECT, for each k with i_valid[k]=1 and captured[k]=0, the block SHALL store the data for node k and set captured[k].
REQ-018 In COLLECT, i_valid[k]=1 while captured[k]=1 SHALL be ignored (the first value wins) and SHALL set o_overrun.
REQ-019 When all captured bits are set, counting captures made in the current cycle, the block SHALL move from COLLECT to STREAM on the next edge; o_valid=1 and o_addr=0 SHALL appear in the cycle after the last capture, including when all nodes are valid in the same cycle.
REQ-020 In STREAM, o_valid SHALL be 1, o_data SHALL equal stored[o_addr], and o_last SHALL equal (o_addr==NUMBER_OF_NODE-1).
REQ-021 A transfer SHALL occur when o_valid and i_ready are both 1; o_addr SHALL then increment by 1.
REQ-022 While i_ready=0, o_data, o_addr and o_last SHALL hold stable.
REQ-023 A transfer with o_last=1 SHALL move the block to DONE, with o_valid=0 in the next cycle.
REQ-024 DONE SHALL last exactly one cycle with o_done=1, then return to COLLECT with all captured bits cleared.
REQ-025 Any i_valid bit asserted in STREAM or DONE SHALL be ignored, SHALL set o_overrun, and SHALL NOT alter stored data.
REQ-026 i_clear=1 in any state SHALL clear all captured bits and move the block to COLLECT, with o_valid=0, o_addr=0 and o_done=0 in the next cycle.
REQ-027 i_clear SHALL also clear o_overrun.
REQ-028 i_clear SHALL take priority over a simultaneous capture or transfer; i_valid bits in the i_clear cycle SHALL be discarded.
REQ-029 Stored data SHALL be passed through unmodified; the block SHALL perform no arithmetic on data.
REQ-030 Throughput SHALL be one word per cycle when i_ready is held at 1, giving NUMBER_OF_NODE cycles of o_valid per layer.
REQ-031 The block SHALL be synthesizable, with no file I/O and no delay statements.

Reset
REQ-032 While rst_n=0, asynchronously: state=COLLECT; captured bits=0; stored data=0; o_data=0; o_addr=0; o_valid=0; o_last=0; o_done=0; o_overrun=0.
REQ-033 rst_n asserted mid-STREAM SHALL abort the stream immediately, with no o_done pulse.
REQ-034 After rst_n is released, the first edge SHALL behave as a normal COLLECT cycle.

Verification
REQ-035 Scenario: with N=4, nodes 2,0,3,1 valid in cycles 1..4 with data 0x40000000+k and i_ready=1 -> o_valid from cycle 5; addresses 0,1,2,3 with matching data; o_last at address 3; o_done in cycle 9.
REQ-036 Scenario: all 4 nodes valid in one cycle T -> o_valid=1 and o_addr=0 at T+1; stream completes at T+4; o_done at T+5.
REQ-037 Scenario: i_ready=0 for 3 cycles at o_addr=1 -> o_addr=1 and o_data held for 3 cycles; total o_valid cycles = 7.
REQ-038 Scenario: node 1 pulses twice in COLLECT, second with data 0xDEADBEEF -> o_overrun=1; the streamed data for node 1 is the first value.
REQ-039 Scenario: i_clear at o_addr=2 during STREAM -> next cycle o_valid=0 with no o_done; a fresh 4-node collection then streams correctly and o_overrun=0.
REQ-040 Scenario: rst_n pulsed low mid-COLLECT with 2 of 4 nodes captured -> all outputs 0; the 2 earlier captures are lost; a subsequent complete collection is required before o_valid.
